// File: rtl/imem_dmem_arb.sv
// Shares one single-port, variable-latency memory between an instruction-fetch port and a data port.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on ties (default build: data always wins ties).
module imem_dmem_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // instruction fetch port
    input  logic                    i_read,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ready,
    // data port
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ready,
    // memory port
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  d_req;
    logic                  grant_d;

    // A simultaneous read+write request is issued as a write.
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic prefer_d;

    assign grant_d = d_req & (~i_read | prefer_d);
`else
    assign grant_d = d_req;
`endif

    // NOTE: ready and the read-data bypass are combinational from mem_ready so the
    // requester sees its word in the same cycle the memory completes; the registered
    // copies only take over once the transaction has retired.
    assign i_ready = (state == BUSY_I) & mem_ready;
    assign d_ready = (state == BUSY_D) & mem_ready;
    assign i_rdata = i_ready ? mem_rdata : i_rdata_q;
    assign d_rdata = d_ready ? mem_rdata : d_rdata_q;

    // NOTE: every register here is written with <= so all of them update from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_d  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= BUSY_D;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                        mem_write <= d_write;
                        mem_read  <= ~d_write;
`ifdef ARB_ROUND_ROBIN_EN
                        prefer_d  <= 1'b0;
`endif
                    end else if (i_read) begin
                        state     <= BUSY_I;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        prefer_d  <= 1'b1;
`endif
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        i_rdata_q <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        d_rdata_q <= mem_rdata;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
